// File: rtl/common_pkg.sv
// Shared definitions for the branch predictor slice.
//   bp_entry_type  : one BTB entry (valid, tag, target, direction counter)
//                    laid out for the default 16-entry / 32-bit / 2-bit case.
//   CTR_STRONG_NT, CTR_WEAK_T, CTR_MAX : direction counter landmarks.
//   ctr_weak_t_val / ctr_max_val       : the same landmarks for any width,
//                                        used by parameterised modules.
package common;

  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX     = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_XLEN - BP_IDX - 1;
  localparam int BP_CTR_W   = 2;

  // Weakly-taken is the lowest value with the MSB set.
  function automatic int ctr_weak_t_val(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int ctr_max_val(input int w);
    return (1 << w) - 1;
  endfunction

  localparam logic [BP_CTR_W-1:0] CTR_STRONG_NT = '0;
  localparam logic [BP_CTR_W-1:0] CTR_WEAK_T    = BP_CTR_W'(ctr_weak_t_val(BP_CTR_W));
  localparam logic [BP_CTR_W-1:0] CTR_MAX       = BP_CTR_W'(ctr_max_val(BP_CTR_W));

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic [BP_CTR_W-1:0] ctr;
  } bp_entry_type;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter step (purely combinational).
//   cur       : current counter value
//   inc       : 1 = count up, 0 = count down (both saturate)
//   force_max : override, result is all-ones
//   next      : resulting counter value
module sat_counter
  import common::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  input  logic         force_max,
  output logic [W-1:0] next
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_comb begin
    next = cur;
    if (force_max) begin
      next = MAX;
    end else if (inc) begin
      if (cur != MAX) next = cur + W'(1);
    end else begin
      if (cur != '0) next = cur - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   lookup_pc             : fetch PC (bit 0 ignored)
//   pred_hit/taken/target : combinational prediction from the table registers
//   resolve*              : branch/jump resolved by decode this cycle
//   flush_tables          : invalidate every entry at the next edge
//   mispredict/redirect_pc: same-cycle squash and corrected fetch PC
//   branch_count, mispredict_count : saturating statistics
module branch_predictor
  import common::*;
#(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              resolve,
  input  logic [XLEN-1:0]   resolve_pc,
  input  logic              resolve_compressed,
  input  logic              resolve_is_jump,
  input  logic              resolve_taken,
  input  logic [XLEN-1:0]   resolve_target,
  input  logic              resolve_pred_taken,
  input  logic [XLEN-1:0]   resolve_pred_target,
  input  logic              flush_tables,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 1;

  localparam logic [CTR_W-1:0] CTR_WEAK_T_L  = CTR_W'(ctr_weak_t_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX_L     = CTR_W'(ctr_max_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WEAK_NT_L = CTR_WEAK_T_L - CTR_W'(1);

  // Same field order as bp_entry_type, sized by this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  entry_t table_q [ENTRIES];

  // ---------------- lookup (combinational, no bypass) ----------------
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  entry_t           lk_entry;

  assign lk_idx   = lookup_pc[IDX:1];
  assign lk_tag   = lookup_pc[XLEN-1:IDX+1];
  assign lk_entry = table_q[lk_idx];

  assign pred_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign pred_taken  = pred_hit && lk_entry.ctr[CTR_W-1];
  assign pred_target = pred_taken ? lk_entry.target : '0;

  // Bit 0 of the fetch PC never participates in indexing or tagging.
  logic unused_lookup_bit;
  assign unused_lookup_bit = lookup_pc[0];

  // ---------------- resolve: mispredict and redirect ----------------
  logic eff_taken;
  assign eff_taken = resolve_is_jump || resolve_taken;

  assign mispredict = resolve &&
                      ((eff_taken != resolve_pred_taken) ||
                       (eff_taken && (resolve_target != resolve_pred_target)));

  assign redirect_pc = eff_taken ? resolve_target
                                 : resolve_pc + (resolve_compressed ? XLEN'(2) : XLEN'(4));

  // ---------------- table update path ----------------
  logic [IDX-1:0]   rs_idx;
  logic [TAG_W-1:0] rs_tag;
  entry_t           rs_entry;
  logic             rs_hit;
  logic [CTR_W-1:0] ctr_next;
  entry_t           wr_entry;
  logic             wr_en;

  assign rs_idx   = resolve_pc[IDX:1];
  assign rs_tag   = resolve_pc[XLEN-1:IDX+1];
  assign rs_entry = table_q[rs_idx];
  assign rs_hit   = rs_entry.valid && (rs_entry.tag == rs_tag);

  sat_counter #(.W(CTR_W)) u_sat_counter (
    .cur       (rs_entry.ctr),
    .inc       (eff_taken),
    .force_max (resolve_is_jump),
    .next      (ctr_next)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = rs_entry;
    if (resolve) begin
      if (rs_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_next;
        if (eff_taken) wr_entry.target = resolve_target;
      end else if (eff_taken) begin
        // Allocation simply replaces whatever aliases into this slot.
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = rs_tag;
        wr_entry.target = resolve_target;
        wr_entry.ctr    = resolve_is_jump ? CTR_MAX_L : CTR_WEAK_T_L;
      end
    end
  end

  // One register per entry; flush has priority over any same-cycle write.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    entry_t entry_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        entry_reg.valid  <= 1'b0;
        entry_reg.tag    <= '0;
        entry_reg.target <= '0;
        entry_reg.ctr    <= CTR_WEAK_NT_L;
      end else if (flush_tables) begin
        entry_reg.valid <= 1'b0;
      end else if (wr_en && (rs_idx == IDX'(gi))) begin
        entry_reg <= wr_entry;
      end
    end

    assign table_q[gi] = entry_reg;
  end

  // ---------------- statistics (saturating, not cleared by flush) ----------------
  logic [STAT_W-1:0] branch_count_reg;
  logic [STAT_W-1:0] mispredict_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (resolve && (branch_count_reg != '1))
        branch_count_reg <= branch_count_reg + STAT_W'(1);
      if (mispredict && (mispredict_count_reg != '1))
        mispredict_count_reg <= mispredict_count_reg + STAT_W'(1);
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (default parameters).
module tb_branch_predictor;

  logic        clk;
  logic        reset_n;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        resolve;
  logic [31:0] resolve_pc;
  logic        resolve_compressed;
  logic        resolve_is_jump;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;
  logic        flush_tables;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  branch_predictor #(.ENTRIES(16), .XLEN(32), .CTR_W(2), .STAT_W(16)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .lookup_pc           (lookup_pc),
    .pred_hit            (pred_hit),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .resolve             (resolve),
    .resolve_pc          (resolve_pc),
    .resolve_compressed  (resolve_compressed),
    .resolve_is_jump     (resolve_is_jump),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .flush_tables        (flush_tables),
    .mispredict          (mispredict),
    .redirect_pc         (redirect_pc),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int bc_model = 0;
  int mc_model = 0;

  typedef struct {
    logic        res, jump, taken, comp, ptaken;
    logic [31:0] pc, tgt, ptgt, lk;
    logic        mp;
    logic [31:0] redir;
    logic        hit, ptk;
    logic [31:0] ptgt_exp;
  } vec_t;

  typedef struct {
    logic        mp;
    logic [31:0] redir;
    logic        chk_redir;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  function automatic vec_t mk(input logic res, input logic jump, input logic taken,
                              input logic comp, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic ptaken, input logic [31:0] ptgt, input logic [31:0] lk,
                              input logic mp, input logic [31:0] redir,
                              input logic hit, input logic ptk, input logic [31:0] ptgt_exp);
    vec_t v;
    v.res = res; v.jump = jump; v.taken = taken; v.comp = comp; v.pc = pc; v.tgt = tgt;
    v.ptaken = ptaken; v.ptgt = ptgt; v.lk = lk; v.mp = mp; v.redir = redir;
    v.hit = hit; v.ptk = ptk; v.ptgt_exp = ptgt_exp;
    return v;
  endfunction

  function automatic int sat16(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic res, input logic jump, input logic taken, input logic comp,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt);
    resolve = res; resolve_is_jump = jump; resolve_taken = taken; resolve_compressed = comp;
    resolve_pc = pc; resolve_target = tgt; resolve_pred_taken = ptaken; resolve_pred_target = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    flush_tables = 1'b0;
  endtask

  // Pops the oldest expectation and compares it with the live resolve outputs.
  task automatic sb_check(input string nm);
    sb_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got mp=%0b expected an entry", nm, mispredict);
      return;
    end
    total--;
    e = sbq.pop_front();
    chk({nm, ".mispredict"}, 32'(mispredict), 32'(e.mp));
    if (e.chk_redir) chk({nm, ".redirect_pc"}, redirect_pc, e.redir);
  endtask

  task automatic sb_push(input logic mp, input logic [31:0] redir, input logic chk_redir);
    sb_t e;
    e.mp = mp; e.redir = redir; e.chk_redir = chk_redir;
    sbq.push_back(e);
  endtask

  task automatic chk_lookup(input string nm, input logic hit, input logic tk, input logic [31:0] tg);
    chk({nm, ".pred_hit"},    32'(pred_hit),   32'(hit));
    chk({nm, ".pred_taken"},  32'(pred_taken), 32'(tk));
    chk({nm, ".pred_target"}, pred_target,     tg);
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, ".branch_count"},     32'(branch_count),     32'(bc_model));
    chk({nm, ".mispredict_count"}, 32'(mispredict_count), 32'(mc_model));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    lookup_pc = 32'h100;
    idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_lookup("reset", 1'b0, 1'b0, 32'h0);
    chk("reset.mispredict", 32'(mispredict), 32'h0);
    chk_counts("reset");
    $display("txn reset lookup=0x100 hit=%0b taken=%0b", pred_hit, pred_taken);

    // resolve  jump tkn cmp pc              tgt       ptk ptgt     lookup         mp redir          hit tk tgt
    vecs.push_back(mk(1, 0, 1, 0, 32'h100,       32'h80,  0, 32'h0,   32'h100,       1, 32'h80,       1, 1, 32'h80));
    vecs.push_back(mk(1, 0, 0, 0, 32'h100,       32'h80,  1, 32'h80,  32'h100,       1, 32'h104,      1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h100,       32'h80,  0, 32'h0,   32'h100,       0, 32'h104,      1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h100,       32'h80,  1, 32'h80,  32'h100,       1, 32'h102,      1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h100,       32'h80,  0, 32'h0,   32'h100,       1, 32'h80,       1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h100,       32'h80,  0, 32'h0,   32'h101,       1, 32'h80,       1, 1, 32'h80));
    vecs.push_back(mk(1, 0, 1, 0, 32'h100,       32'h80,  1, 32'h80,  32'h100,       0, 32'h80,       1, 1, 32'h80));
    vecs.push_back(mk(1, 0, 1, 0, 32'h100,       32'h88,  1, 32'h80,  32'h100,       1, 32'h88,       1, 1, 32'h88));
    vecs.push_back(mk(1, 0, 1, 0, 32'h120,       32'h300, 0, 32'h0,   32'h100,       1, 32'h300,      0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0,   0, 32'h0,   32'h120,       0, 32'h4,        1, 1, 32'h300));
    vecs.push_back(mk(1, 0, 0, 0, 32'h146,       32'h999, 0, 32'h0,   32'h146,       0, 32'h14a,      0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 0, 32'h200,       32'h400, 0, 32'h0,   32'h200,       1, 32'h400,      1, 1, 32'h400));
    vecs.push_back(mk(1, 0, 0, 0, 32'h200,       32'h400, 1, 32'h400, 32'h200,       1, 32'h204,      1, 1, 32'h400));
    vecs.push_back(mk(1, 1, 0, 0, 32'h200,       32'h400, 1, 32'h400, 32'h200,       0, 32'h400,      1, 1, 32'h400));
    vecs.push_back(mk(1, 0, 0, 0, 32'h200,       32'h400, 1, 32'h400, 32'h200,       1, 32'h204,      1, 1, 32'h400));
    vecs.push_back(mk(1, 0, 0, 0, 32'h200,       32'h400, 1, 32'h400, 32'h200,       1, 32'h204,      1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h200,       32'h500, 0, 32'h0,   32'h200,       1, 32'h500,      1, 1, 32'h500));
    vecs.push_back(mk(1, 0, 0, 0, 32'h200,       32'h500, 1, 32'h500, 32'h200,       1, 32'h204,      1, 1, 32'h500));
    vecs.push_back(mk(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,   0, 32'h0,   32'hFFFF_FFFC, 0, 32'h0,        0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(vecs[i].res, vecs[i].jump, vecs[i].taken, vecs[i].comp,
            vecs[i].pc, vecs[i].tgt, vecs[i].ptaken, vecs[i].ptgt);
      sb_push(vecs[i].mp, vecs[i].redir, vecs[i].res);
      #1;
      sb_check(nm);
      $display("txn %s pc=0x%0h mp=%0b redir=0x%0h", nm, vecs[i].pc, mispredict, redirect_pc);
      if (vecs[i].res) bc_model = sat16(bc_model + 1);
      if (vecs[i].mp)  mc_model = sat16(mc_model + 1);
      @(negedge clk);
      idle();
      lookup_pc = vecs[i].lk;
      #1;
      chk_lookup(nm, vecs[i].hit, vecs[i].ptk, vecs[i].ptgt_exp);
      chk_counts(nm);
    end

    // Flush together with an allocating resolve: nothing valid afterwards.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h80, 1'b0, 32'h0);
    flush_tables = 1'b1;
    sb_push(1'b1, 32'h80, 1'b1);
    #1;
    sb_check("flush");
    $display("txn flush pc=0x300 mp=%0b", mispredict);
    bc_model = sat16(bc_model + 1);
    mc_model = sat16(mc_model + 1);
    @(negedge clk);
    idle();
    lookup_pc = 32'h300;
    #1;
    chk_lookup("flush.new", 1'b0, 1'b0, 32'h0);
    chk_counts("flush");
    lookup_pc = 32'h200;
    #1;
    chk_lookup("flush.old", 1'b0, 1'b0, 32'h0);

    // Statistics saturation: continuous mispredicting not-taken misses.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 1'b1, 32'h0);
    repeat (65600) @(negedge clk);
    bc_model = sat16(bc_model + 65600);
    mc_model = sat16(mc_model + 65600);
    idle();
    #1;
    chk("sat.branch_count_max",     32'(branch_count),     32'hFFFF);
    chk_counts("sat");
    $display("txn saturate burst=65600 bc=0x%0h mc=0x%0h", branch_count, mispredict_count);

    // Allocate an entry, then assert reset mid-update.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 32'h0);
    @(negedge clk);
    idle();
    lookup_pc = 32'h100;
    #1;
    chk_lookup("prereset", 1'b1, 1'b1, 32'h80);
    $display("txn prereset alloc pc=0x100 hit=%0b", pred_hit);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h110, 32'h90, 1'b0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_lookup("midreset", 1'b0, 1'b0, 32'h0);
    chk("midreset.branch_count",     32'(branch_count),     32'h0);
    chk("midreset.mispredict_count", 32'(mispredict_count), 32'h0);
    sb_push(1'b1, 32'h90, 1'b1);
    sb_check("midreset.resolve");
    idle();
    sb_push(1'b0, 32'h0, 1'b0);
    #1;
    sb_check("midreset.idle");
    $display("txn midreset hit=%0b bc=0x%0h", pred_hit, branch_count);
    @(negedge clk);
    reset_n = 1'b1;
    bc_model = 0;
    mc_model = 0;
    lookup_pc = 32'h110;
    #1;
    chk_lookup("postreset", 1'b0, 1'b0, 32'h0);
    chk_counts("postreset");

    // First edge after release performs a normal update.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h110, 32'h90, 1'b0, 32'h0);
    @(negedge clk);
    idle();
    bc_model = 1;
    mc_model = 1;
    #1;
    chk_lookup("firstedge", 1'b1, 1'b1, 32'h90);
    chk_counts("firstedge");
    $display("txn firstedge pc=0x110 hit=%0b tgt=0x%0h", pred_hit, pred_target);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters. It is the next generation of the decode-side branch resolution logic. Fetch queries it every cycle with the current PC and gets a predicted next PC. Decode reports each resolved branch or jump; the block then signals mispredict and redirect in the same cycle and trains its table at the clock edge.

## Interface
- ENTRIES, 16, number of BTB entries; power of 2, ≥2; IDX = log2(ENTRIES)
- XLEN, 32, address width
- CTR_W, 2, direction counter width
- STAT_W, 16, width of the statistics counters
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- lookup_pc  in  XLEN  fetch PC; bit 0 is ignored
- pred_hit  out  1  valid entry whose tag matches lookup_pc
- pred_taken  out  1  pred_hit and counter MSB set
- pred_target  out  XLEN  stored target when pred_taken is 1, else 0
- resolve  in  1  decode resolved a control-transfer instruction this cycle
- resolve_pc  in  XLEN  PC of the resolved instruction
- resolve_compressed  in  1  resolved instruction is 16-bit
- resolve_is_jump  in  1  JAL/JALR; always taken
- resolve_taken  in  1  actual direction; ignored when resolve_is_jump is 1
- resolve_target  in  XLEN  actual target
- resolve_pred_taken  in  1  prediction carried through IF/ID
- resolve_pred_target  in  XLEN  predicted target carried through IF/ID
- flush_tables  in  1  synchronous invalidate of all entries (fence.i)
- mispredict  out  1  squash IF/ID and redirect fetch
- redirect_pc  out  XLEN  correct next PC; valid when mispredict is 1
- branch_count  out  STAT_W  number of resolves, saturating
- mispredict_count  out  STAT_W  number of mispredicts, saturating

## Operation
- Index: pc[IDX:1]. Tag: pc[XLEN-1:IDX+1].
- Each entry holds: valid, tag, target, ctr.
- Counter encoding: 0 = strong-NT, 1 = weak-NT, 2 = weak-T, 3 = strong-T; generalised to CTR_W bits, taken when the MSB is set.
- Lookup is purely combinational from the table registers. No bypass from a same-cycle update.
- Effective taken (eff_taken) = resolve_is_jump OR resolve_taken.
- mispredict = resolve AND (eff_taken != resolve_pred_taken OR (eff_taken AND resolve_target != resolve_pred_target)).
- redirect_pc = resolve_target when eff_taken is 1; otherwise resolve_pc + 2 when resolve_compressed is 1, else resolve_pc + 4. Addition wraps modulo 2^XLEN.
- Update at the edge while resolve is 1:
  - Hit: the counter saturates up if eff_taken, saturates down otherwise. The target is overwritten when eff_taken is 1.
  - Jump hit: the counter is forced to its maximum.
  - Miss and eff_taken: allocate by overwriting the indexed entry. Set valid, tag and target. The counter is set to its maximum for jumps, otherwise to 2^(CTR_W-1) (weak-T).
  - Miss and not taken: no write.
- Statistics: branch_count increments on every resolve. mispredict_count increments when mispredict is 1. Both hold at all-ones. flush_tables does not clear them.
- Simultaneous events:
  - flush_tables wins over an update in the same cycle; all valid bits clear and no allocation occurs.
  - mispredict and the statistics still evaluate normally in that cycle.

## Timing
- Lookup has 0-cycle latency.
- mispredict and redirect_pc have 0-cycle latency from the resolve inputs, matching the same-cycle squash in decode.
- A table update is visible to lookup from the cycle after the resolve.
- Reset (asynchronous, any cycle, including mid-update):
  - all valid = 0, all ctr = 1 (weak-NT), targets and tags = 0;
  - counters = 0;
  - pred_hit, pred_taken, pred_target = 0;
  - mispredict is 0 unless resolve is driven.
- After reset is released, the first edge performs normal updates.

## Structure
- Shared package common gets:
  - bp_entry_type, a struct holding valid, tag, target and ctr;
  - the localparams CTR_STRONG_NT, CTR_WEAK_T and CTR_MAX, expressed in CTR_W terms.
- The width-dependent fields are parameterised inside the module using that struct's layout.
- Sub-module sat_counter (parameter W): inputs cur, inc, force_max; output next. It is purely combinational and instantiated once on the update path.
- The table is a register array with the asynchronous reset loop; no SRAM macro is used.

## Test plan
- Reset, then lookup_pc = 0x100 → pred_hit = 0, pred_taken = 0, pred_target = 0, mispredict = 0.
- Resolve taken branch at pc 0x100 to target 0x80, predicted not-taken:
  - same cycle: mispredict = 1, redirect_pc = 0x80;
  - next cycle: lookup 0x100 gives pred_taken = 1, pred_target = 0x80, branch_count = 1, mispredict_count = 1.
- Same entry resolved not-taken three times → counter 2→1→0→0; pred_taken = 0 after the first resolve. Compressed, not-taken, predicted taken gives redirect_pc = 0x102.
- Aliasing: allocate 0x100, then resolve a taken branch at 0x100 + 2·ENTRIES (0x120 with ENTRIES = 16) → the entry is replaced; lookup 0x100 gives pred_hit = 0.
- JAL at 0x200 to target 0x400 → allocated with counter 3. A later resolve_taken = 0 with resolve_is_jump = 1 keeps pred_taken = 1. A hit with a changed target (JALR) overwrites the target.
- Edge cases:
  - flush_tables with resolve in the same cycle → no entries valid afterwards;
  - drive mispredicts past 2^STAT_W − 1 → mispredict_count holds at all-ones;
  - assert reset_n low mid-update → table cleared immediately.
